muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_if.sv | 27 ++
 rtl/muldiv_ctrl.sv | 144 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// HI/LO unit bus: operation request, move-to writes, read hazard, and the architectural results.
// The master modport is the pipeline side, and the slave modport is muldiv_ctrl.
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, wr_data, rd_req,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, wr_data, rd_req,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide (shift-add / restoring). The result arrives 34 cycles after start; MULDIV_FAST_MULT_EN makes multiplies finish in 2.
// There is no backpressure: start is ignored while busy, and stall holds the pipeline on HI/LO access during an operation.
module muldiv_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] md_q, md_d;   // multiplicand or divisor magnitude
  logic [31:0] mr_q, mr_d;   // multiplier or dividend magnitude, consumed one bit per step
  logic        is_div_q, is_div_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] add_sum, rem_sh, sub_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    rs_neg   = ~bus.op[0] & bus.rs_val[31];
    rt_neg   = ~bus.op[0] & bus.rt_val[31];
    rs_mag   = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag   = rt_neg ? -bus.rt_val : bus.rt_val;
    add_sum  = {1'b0, acc_q[63:32]} + {1'b0, (mr_q[0] ? md_q : 32'd0)};
    rem_sh   = {acc_q[63:32], mr_q[31]};
    sub_diff = rem_sh - {1'b0, md_q};
    prod_fix = qneg_q ? -acc_q : acc_q;
    // Divide by zero already yields an all-ones quotient; negating it would break that.
    quo_fix  = (qneg_q & ~dz_q) ? -acc_q[31:0] : acc_q[31:0];
    rem_fix  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    md_d     = md_q;
    mr_d     = mr_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          md_d     = bus.op[1] ? rt_mag : rs_mag;
          mr_d     = bus.op[1] ? rs_mag : rt_mag;
          qneg_d   = rs_neg ^ rt_neg;
          rneg_d   = rs_neg;
          dz_d     = bus.op[1] & (bus.rt_val == 32'd0);
          acc_d    = 64'd0;
          cnt_d    = 6'd0;
          state_d  = RUN;
`ifdef MULDIV_FAST_MULT_EN
          if (!bus.op[1]) begin
            acc_d   = {32'd0, rs_mag} * {32'd0, rt_mag};
            state_d = FIX;
          end
`endif
        end else begin
          if (bus.mthi) hi_d = bus.wr_data;
          if (bus.mtlo) lo_d = bus.wr_data;
        end
      end
      RUN: begin
        if (is_div_q) begin
          // Remainder in acc[63:32]; quotient bits shift into acc[31:0].
          acc_d = {(sub_diff[32] ? rem_sh[31:0] : sub_diff[31:0]), acc_q[30:0], ~sub_diff[32]};
          mr_d  = {mr_q[30:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[31:1]};
          mr_d  = {1'b0, mr_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_q == FIX);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      md_q     <= 32'd0;
      mr_q     <= 32'd0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      md_q     <= md_d;
      mr_q     <= mr_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.rd_req | bus.mthi | bus.mtlo);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: reset, multiply/divide results and timing, move-to writes, stall, and mid-operation reset.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_CYC  = 2;
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_CYC  = 34;
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_CYC  = 34;
  localparam int DIV_BUSY = 33;

  muldiv_ctrl_if bus ();
  muldiv_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int          cyc, bcnt;
  logic [31:0] h, l;
  logic        p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and collect the done cycle, busy-cycle count, result and the cycle after done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int c, output int bc, output logic [31:0] rh, output logic [31:0] rl,
                       output logic after);
    bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 1; bc = 0;
    while (bus.done !== 1'b1 && c < 200) begin
      if (bus.busy === 1'b1) bc++;
      tick();
      c++;
    end
    rh = bus.hi; rl = bus.lo;
    tick();
    after = bus.done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.wr_data = 0; bus.rd_req = 0;
    repeat (3) tick();
    checks++; if ({bus.hi, bus.lo} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", {bus.hi, bus.lo}); end
    checks++; if ({bus.busy, bus.done, bus.stall} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.stall}); end
    @(negedge clk);
    reset_n = 1'b1;
    bus.op = 2'b01; bus.rs_val = 32'd5; bus.rt_val = 32'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_first_start busy got=%b exp=1", bus.busy); end
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    checks++; if (cyc !== MUL_CYC || bus.lo !== 32'd30) begin failures++; $display("FAIL reset_first_result cyc=%0d lo=%h exp cyc=%0d lo=1e", cyc, bus.lo, MUL_CYC); end
    tick();
  endtask

  task automatic test_mult();
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bcnt, h, l, p2);
    checks++; if ({h, l} !== 64'hFFFFFFFE_00000001) begin failures++; $display("FAIL multu_max got=%h exp=fffffffe00000001", {h, l}); end
    checks++; if (cyc !== MUL_CYC) begin failures++; $display("FAIL multu_done_cycle got=%0d exp=%0d", cyc, MUL_CYC); end
    checks++; if (bcnt !== MUL_BUSY) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=%0d", bcnt, MUL_BUSY); end
    checks++; if (p2 !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got=%b exp=0", p2); end
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000007, cyc, bcnt, h, l, p2);
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFEB) begin failures++; $display("FAIL mult_neg got=%h exp=ffffffffffffffeb", {h, l}); end
    do_op(2'b00, 32'h80000000, 32'h80000000, cyc, bcnt, h, l, p2);
    checks++; if ({h, l} !== 64'h40000000_00000000) begin failures++; $display("FAIL mult_minmin got=%h exp=4000000000000000", {h, l}); end
  endtask

  task automatic test_div();
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, cyc, bcnt, h, l, p2);
    checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", h, l); end
    checks++; if (cyc !== DIV_CYC || bcnt !== DIV_BUSY) begin failures++; $display("FAIL div_timing got cyc=%0d busy=%0d exp cyc=%0d busy=%0d", cyc, bcnt, DIV_CYC, DIV_BUSY); end
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, cyc, bcnt, h, l, p2);
    checks++; if (h !== 32'h0 || l !== 32'h80000000) begin failures++; $display("FAIL div_overflow got hi=%h lo=%h exp hi=0 lo=80000000", h, l); end
    do_op(2'b10, 32'h00000007, 32'hFFFFFFFE, cyc, bcnt, h, l, p2);
    checks++; if (h !== 32'h1 || l !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negdivisor got hi=%h lo=%h exp hi=1 lo=fffffffd", h, l); end
  endtask

  task automatic test_div_zero();
    do_op(2'b11, 32'h00000005, 32'h0, cyc, bcnt, h, l, p2);
    checks++; if (h !== 32'h5 || l !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_zero got hi=%h lo=%h exp hi=5 lo=ffffffff", h, l); end
    checks++; if (cyc !== 34) begin failures++; $display("FAIL divu_zero_cycle got=%0d exp=34", cyc); end
    do_op(2'b10, 32'hFFFFFFF0, 32'h0, cyc, bcnt, h, l, p2);
    checks++; if (h !== 32'hFFFFFFF0 || l !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_zero_neg got hi=%h lo=%h exp hi=fffffff0 lo=ffffffff", h, l); end
  endtask

  task automatic test_move();
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wr_data = 32'h0000005A;
    tick();
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    checks++; if (bus.hi !== 32'h5A || bus.lo !== 32'h5A) begin failures++; $display("FAIL mt_both got hi=%h lo=%h exp 5a/5a", bus.hi, bus.lo); end
    bus.mthi = 1'b1; bus.wr_data = 32'h0000A5A5;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b1; bus.wr_data = 32'h00001234;
    tick();
    bus.mtlo = 1'b0;
    checks++; if (bus.hi !== 32'hA5A5 || bus.lo !== 32'h1234) begin failures++; $display("FAIL mt_single got hi=%h lo=%h exp a5a5/1234", bus.hi, bus.lo); end
    bus.op = 2'b01; bus.rs_val = 32'h00010000; bus.rt_val = 32'h00030000;
    bus.start = 1'b1; bus.mthi = 1'b1; bus.wr_data = 32'hDEADBEEF;
    tick();
    bus.start = 1'b0; bus.mthi = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.hi !== 32'hA5A5) begin failures++; $display("FAIL start_beats_mthi got busy=%b hi=%h exp busy=1 hi=a5a5", bus.busy, bus.hi); end
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    checks++; if (bus.hi !== 32'h3 || bus.lo !== 32'h0) begin failures++; $display("FAIL start_beats_mthi_result got hi=%h lo=%h exp 3/0", bus.hi, bus.lo); end
    tick();
  endtask

  task automatic test_stall();
    bus.op = 2'b11; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.rd_req = 1'b1; bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd1; bus.rt_val = 32'd1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_rd_req got=%b exp=1", bus.stall); end
    tick();
    bus.rd_req = 1'b0; bus.start = 1'b0;
    bus.mthi = 1'b1; bus.wr_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_mthi got=%b exp=1", bus.stall); end
    tick();
    bus.mthi = 1'b0;
    checks++; if (bus.hi !== 32'h3) begin failures++; $display("FAIL mthi_while_busy got=%h exp=3", bus.hi); end
    cyc = 7;
    while (bus.done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    checks++; if (cyc !== 34 || bus.hi !== 32'd2 || bus.lo !== 32'd14) begin failures++; $display("FAIL stall_first_result got cyc=%0d hi=%h lo=%h exp 34/2/e", cyc, bus.hi, bus.lo); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_idle got=%b exp=0", bus.stall); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.op = 2'b01; bus.rs_val = 32'd2; bus.rt_val = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    checks++; if (cyc !== MUL_CYC || bus.lo !== 32'd6) begin failures++; $display("FAIL b2b_first got cyc=%0d lo=%h exp %0d/6", cyc, bus.lo, MUL_CYC); end
    bus.op = 2'b11; bus.rs_val = 32'd9; bus.rt_val = 32'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", bus.busy); end
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    checks++; if (cyc !== 34 || bus.hi !== 32'd1 || bus.lo !== 32'd2) begin failures++; $display("FAIL b2b_second got cyc=%0d hi=%h lo=%h exp 34/1/2", cyc, bus.hi, bus.lo); end
    tick();
  endtask

  task automatic test_reset_mid();
    int dcnt;
    bus.op = 2'b10; bus.rs_val = 32'd100; bus.rt_val = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0; bus.rd_req = 1'b1;
    #1;
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin failures++; $display("FAIL midreset_hilo got hi=%h lo=%h exp 0/0", bus.hi, bus.lo); end
    checks++; if ({bus.busy, bus.done, bus.stall} !== 3'b000) begin failures++; $display("FAIL midreset_flags got=%b exp=000", {bus.busy, bus.done, bus.stall}); end
    tick(); tick();
    reset_n = 1'b1; bus.rd_req = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) dcnt++;
    end
    checks++; if (dcnt !== 0 || bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_no_done got done_pulses=%0d busy=%b exp 0/0", dcnt, bus.busy); end
    do_op(2'b01, 32'd3, 32'd4, cyc, bcnt, h, l, p2);
    checks++; if (h !== 32'd0 || l !== 32'd12) begin failures++; $display("FAIL midreset_multu got hi=%h lo=%h exp 0/c", h, l); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_move();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
